// File: rtl/mmu_pkg.sv
// rtl/mmu_pkg.sv - shared types and field positions for the TLB-based MMU
package mmu_pkg;

    localparam int PTE_V  = 0;
    localparam int PTE_W  = 1;

    localparam int VPN_HI = 31;
    localparam int VPN_LO = 12;
    localparam int DIR_HI = 31;
    localparam int DIR_LO = 22;
    localparam int TBL_HI = 21;
    localparam int TBL_LO = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PDE_RD,
        S_PTE_RD,
        S_FAULT
    } mmu_state_e;

    typedef struct packed {
        logic        valid;
        logic [19:0] vpn;
        logic [19:0] ppn;
        logic        w;
    } tlb_entry_t;

endpackage

// File: rtl/mmu_tlb_array.sv
// rtl/mmu_tlb_array.sv - fully-associative TLB storage, lookup, victim choice and flush
module mmu_tlb_array
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 4,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [19:0]      lookup_vpn_i,
    input  logic             flush_i,
    input  logic             fill_i,
    input  logic [19:0]      fill_vpn_i,
    input  logic [19:0]      fill_ppn_i,
    input  logic             fill_w_i,
    output logic             hit_o,
    output logic [IDX_W-1:0] hit_idx_o,
    output logic [19:0]      hit_ppn_o,
    output logic             hit_w_o
);

    tlb_entry_t       entry_q [TLB_ENTRIES];
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] victim;
    logic             have_free;

    always_comb begin
        hit_o     = 1'b0;
        hit_idx_o = '0;
        hit_ppn_o = '0;
        hit_w_o   = 1'b0;
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            if (entry_q[i].valid && entry_q[i].vpn == lookup_vpn_i) begin
                hit_o     = 1'b1;
                hit_idx_o = IDX_W'(i);
                hit_ppn_o = entry_q[i].ppn;
                hit_w_o   = entry_q[i].w;
            end
        end
    end

    // Descending scan leaves the lowest-index free slot as the victim.
    always_comb begin
        have_free = 1'b0;
        victim    = ptr_q;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (!entry_q[i].valid) begin
                have_free = 1'b1;
                victim    = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (flush_i) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (fill_i) begin
            entry_q[victim] <= '{valid: 1'b1, vpn: fill_vpn_i, ppn: fill_ppn_i, w: fill_w_i};
            if (!have_free) begin
                ptr_q <= ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmu_tlbn.sv
// rtl/mmu_tlbn.sv - MMU with N-entry TLB and two-level page-table walker
module mmu_tlbn
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 4,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mmu_base_i,
    input  logic        mmu_we,
    output logic [31:0] mmu_base_o,
    input  logic [31:0] v_addr_i,
    input  logic [31:0] v_data_i,
    output logic [31:0] v_data_o,
    input  logic        v_we_i,
    input  logic        v_rd_i,
    output logic        v_ack_o,
    output logic [31:0] addr_o,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        we_o,
    output logic        rd_o,
    input  logic        ack_i,
    output logic        page_fault,
    output logic [31:0] page_fault_addr
);

    mmu_state_e       state_q, state_d;
    logic [31:0]      base_q;
    logic [31:0]      pf_addr_q;
    logic [19:0]      vpn_q, vpn_d;
    logic [19:0]      pde_q, pde_d;
    logic             req;
    logic             hit;
    logic             hit_w;
    logic [IDX_W-1:0] hit_idx;
    logic [19:0]      hit_ppn;
    logic             fill;

    assign req             = v_rd_i | v_we_i;
    assign v_data_o        = data_i;
    assign mmu_base_o      = base_q;
    assign page_fault_addr = pf_addr_q;

    mmu_tlb_array #(
        .TLB_ENTRIES (TLB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_tlb (
        .clk          (clk),
        .rst          (rst),
        .lookup_vpn_i (v_addr_i[VPN_HI:VPN_LO]),
        .flush_i      (mmu_we),
        .fill_i       (fill),
        .fill_vpn_i   (vpn_q),
        .fill_ppn_i   (data_i[31:12]),
        .fill_w_i     (data_i[PTE_W]),
        .hit_o        (hit),
        .hit_idx_o    (hit_idx),
        .hit_ppn_o    (hit_ppn),
        .hit_w_o      (hit_w)
    );

    always_comb begin
        state_d    = state_q;
        vpn_d      = vpn_q;
        pde_d      = pde_q;
        fill       = 1'b0;
        addr_o     = '0;
        data_o     = '0;
        we_o       = 1'b0;
        rd_o       = 1'b0;
        v_ack_o    = 1'b0;
        page_fault = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_d = S_PDE_RD;
                        vpn_d   = v_addr_i[VPN_HI:VPN_LO];
                    end else if (v_we_i && !hit_w) begin
                        state_d = S_FAULT;
                    end else begin
                        addr_o  = {hit_ppn, v_addr_i[11:0]};
                        data_o  = v_data_i;
                        we_o    = v_we_i;
                        rd_o    = v_rd_i;
                        v_ack_o = ack_i;
                    end
                end
            end
            S_PDE_RD: begin
                rd_o   = 1'b1;
                addr_o = {base_q[31:12], vpn_q[19:10], 2'b00};
                if (ack_i) begin
                    pde_d   = data_i[31:12];
                    state_d = data_i[PTE_V] ? S_PTE_RD : S_FAULT;
                end
            end
            S_PTE_RD: begin
                rd_o   = 1'b1;
                addr_o = {pde_q, vpn_q[9:0], 2'b00};
                if (ack_i) begin
                    fill    = data_i[PTE_V];
                    state_d = data_i[PTE_V] ? S_IDLE : S_FAULT;
                end
            end
            S_FAULT: begin
                page_fault = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // A base write abandons any walk and suppresses a coincident fill.
        if (mmu_we) begin
            state_d = S_IDLE;
            fill    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            pf_addr_q <= '0;
            vpn_q     <= '0;
            pde_q     <= '0;
        end else begin
            state_q <= state_d;
            vpn_q   <= vpn_d;
            pde_q   <= pde_d;
            if (mmu_we) begin
                base_q <= mmu_base_i;
            end
            if (state_q == S_FAULT) begin
                pf_addr_q <= v_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_mmu_tlbn.sv
// tb/tb_mmu_tlbn.sv - randomized self-checking bench for mmu_tlbn against a page-table model
module tb_mmu_tlbn;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mmu_base_i = '0;
    logic        mmu_we = 1'b0;
    logic [31:0] mmu_base_o;
    logic [31:0] v_addr_i = '0;
    logic [31:0] v_data_i = '0;
    logic [31:0] v_data_o;
    logic        v_we_i = 1'b0;
    logic        v_rd_i = 1'b0;
    logic        v_ack_o;
    logic [31:0] addr_o;
    logic [31:0] data_i = '0;
    logic [31:0] data_o;
    logic        we_o;
    logic        rd_o;
    logic        ack_i = 1'b0;
    logic        page_fault;
    logic [31:0] page_fault_addr;

    always #5 clk = ~clk;

    mmu_tlbn #(.TLB_ENTRIES(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .mmu_base_i      (mmu_base_i),
        .mmu_we          (mmu_we),
        .mmu_base_o      (mmu_base_o),
        .v_addr_i        (v_addr_i),
        .v_data_i        (v_data_i),
        .v_data_o        (v_data_o),
        .v_we_i          (v_we_i),
        .v_rd_i          (v_rd_i),
        .v_ack_o         (v_ack_o),
        .addr_o          (addr_o),
        .data_i          (data_i),
        .data_o          (data_o),
        .we_o            (we_o),
        .rd_o            (rd_o),
        .ack_i           (ack_i),
        .page_fault      (page_fault),
        .page_fault_addr (page_fault_addr)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: sparse memory plus an abstract 4-slot TLB.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] m_base;
    bit          m_valid [4];
    logic [19:0] m_vpn   [4];
    logic [19:0] m_ppn   [4];
    bit          m_w     [4];
    int          m_ptr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic model_flush(input logic [31:0] b);
        m_base = b;
        for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
        m_ptr = 0;
    endtask

    task automatic set_base(input logic [31:0] b);
        @(negedge clk);
        mmu_base_i = b;
        mmu_we     = 1'b1;
        @(negedge clk);
        mmu_we     = 1'b0;
        model_flush(b);
    endtask

    task automatic access(input bit wr, input logic [31:0] va);
        logic [31:0] exp_q[$];
        logic [31:0] obs_q[$];
        logic [31:0] pde, pte, wd;
        bit exp_fault = 0, got_fault = 0, got_ack = 0, saw_we = 0, done = 0, hit_now;
        int hi = -1, vic, n;
        for (int i = 0; i < 4; i++)
            if (m_valid[i] && m_vpn[i] == va[31:12]) hi = i;
        hit_now = (hi >= 0);
        if (!hit_now) begin
            exp_q.push_back({m_base[31:12], va[31:22], 2'b00});
            pde = mem_rd(exp_q[0]);
            if (!pde[0]) exp_fault = 1;
            else begin
                exp_q.push_back({pde[31:12], va[21:12], 2'b00});
                pte = mem_rd(exp_q[1]);
                if (!pte[0]) exp_fault = 1;
                else begin
                    vic = -1;
                    for (int i = 3; i >= 0; i--) if (!m_valid[i]) vic = i;
                    if (vic < 0) begin
                        vic   = m_ptr;
                        m_ptr = (m_ptr + 1) % 4;
                    end
                    m_valid[vic] = 1'b1;
                    m_vpn[vic]   = va[31:12];
                    m_ppn[vic]   = pte[31:12];
                    m_w[vic]     = pte[1];
                    hi = vic;
                end
            end
        end
        if (!exp_fault) begin
            if (wr && !m_w[hi]) exp_fault = 1;
            else exp_q.push_back({m_ppn[hi], va[11:0]});
        end

        wd       = $urandom;
        v_addr_i = va;
        v_data_i = wd;
        v_we_i   = wr;
        v_rd_i   = !wr;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            if (cyc == 0 && hit_now && !exp_fault) chk("hit_addr", addr_o, exp_q[0]);
            data_i = mem_rd(addr_o);
            ack_i  = (rd_o || we_o) && ($urandom_range(0, 1) == 1);
            #1;
            if (we_o) saw_we = 1;
            if (ack_i && (rd_o || we_o)) obs_q.push_back(addr_o);
            if (v_ack_o) begin
                got_ack = 1;
                done    = 1;
                chk("rdata", v_data_o, data_i);
                if (wr) chk("wdata", data_o, wd);
            end
            if (page_fault) begin
                got_fault = 1;
                done      = 1;
            end
        end
        @(posedge clk);
        #1;
        ack_i  = 1'b0;
        v_rd_i = 1'b0;
        v_we_i = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("fault", 32'(got_fault), 32'(exp_fault));
        chk("vack", 32'(got_ack), 32'(!exp_fault));
        chk("we_seen", 32'(saw_we), 32'(wr && !exp_fault));
        chk("nbus", 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("bus_addr", obs_q[i], exp_q[i]);
        if (exp_fault) chk("pf_addr", page_fault_addr, va);
        chk("pf_pulse", 32'(page_fault), 32'd0);
    endtask

    task automatic abort_test(input logic [31:0] va, input logic [31:0] nb);
        logic [31:0] pde_a, pte_a;
        bit found = 0;
        pde_a    = {m_base[31:12], va[31:22], 2'b00};
        pte_a    = {mem_rd(pde_a) >> 12, va[21:12], 2'b00};
        v_addr_i = va;
        v_rd_i   = 1'b1;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(negedge clk);
            data_i = mem_rd(addr_o);
            ack_i  = rd_o && (addr_o == pde_a);
            if (rd_o && addr_o == pte_a) begin
                found = 1;
                ack_i = 1'b0;
            end
        end
        chk("abort_reach", 32'(found), 32'd1);
        mmu_base_i = nb;
        mmu_we     = 1'b1;
        v_rd_i     = 1'b0;
        @(posedge clk);
        #1;
        mmu_we = 1'b0;
        chk("abort_rd", 32'(rd_o), 32'd0);
        chk("abort_base", mmu_base_o, nb);
        data_i = mem_rd(pte_a);
        ack_i  = 1'b1;
        @(posedge clk);
        #1;
        ack_i = 1'b0;
        chk("late_ack_rd", 32'(rd_o), 32'd0);
        chk("late_ack_vack", 32'(v_ack_o), 32'd0);
        chk("late_ack_pf", 32'(page_fault), 32'd0);
        model_flush(nb);
    endtask

    initial begin
        model_flush(32'h0);
        mem[32'h0001_0004] = 32'h0002_0001;
        mem[32'h0001_0008] = 32'h0000_0000;
        mem[32'h0001_000C] = 32'h0003_0001;
        mem[32'h0007_0004] = 32'h0002_0001;
        mem[32'h0007_0008] = 32'h0000_0000;
        mem[32'h0007_000C] = 32'h0003_0001;
        mem[32'h0002_008C] = 32'h0005_5003;
        mem[32'h0002_0090] = 32'h0006_6001;
        for (int i = 0; i < 5; i++)
            mem[32'h0002_0094 + 32'(i * 4)] = 32'h0008_0003 + 32'(i << 12);
        for (int i = 0; i < 8; i++) begin
            mem[32'h0002_0000 + 32'(i * 4)] = {12'h001, 8'($urandom), 10'h0,
                                               1'($urandom), 1'($urandom_range(0, 4) != 0)};
            mem[32'h0003_0000 + 32'(i * 4)] = {12'h002, 8'($urandom), 10'h0,
                                               1'($urandom), 1'($urandom_range(0, 4) != 0)};
        end

        #12;
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_vack", 32'(v_ack_o), 32'd0);
        chk("rst_addr", addr_o, 32'h0);
        chk("rst_pf", 32'(page_fault), 32'd0);
        chk("rst_pf_addr", page_fault_addr, 32'h0);
        chk("rst_base", mmu_base_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        set_base(32'h0001_0000);
        chk("base", mmu_base_o, 32'h0001_0000);
        access(1'b0, 32'h0042_3ABC);
        access(1'b0, 32'h0042_3FF0);
        access(1'b1, 32'h0042_4010);
        access(1'b1, 32'h0042_4020);

        set_base(32'h0001_0000);
        for (int i = 0; i < 5; i++) access(1'b0, 32'h0042_5000 + 32'(i << 12));
        access(1'b0, 32'h0042_5004);
        access(1'b1, 32'h0042_9008);

        access(1'b0, 32'h0080_0123);
        access(1'b0, 32'h0080_0123);

        set_base(32'h0001_0000);
        abort_test(32'h0040_0000, 32'h0007_0000);
        access(1'b0, 32'h0042_3ABC);
        access(1'b0, 32'h0040_0010);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 19) == 0)
                set_base(($urandom_range(0, 1) == 1) ? 32'h0007_0000 : 32'h0001_0000);
            else
                access(1'($urandom), {10'($urandom_range(1, 3)), 10'($urandom_range(0, 7)),
                                      12'($urandom)});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/mmu_tlbn.md
Name: mmu_tlbn

Overview:
- Parametrised successor to the single-entry last-page MMU.
- Translates CPU virtual accesses to physical bus accesses through an N-entry fully-associative TLB, refilled by an internal two-level page-table walker.
- Adds write-protection faults, flush on base write, and abort of an in-flight walk.
- Sits between the CPU data port and the system bus.

Parameters:
- TLB_ENTRIES, 4, number of TLB entries; power of two, 2..16.
- IDX_W, $clog2(TLB_ENTRIES), derived; width of the entry index and replacement pointer.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mmu_base_i  in  32  page-directory base; [31:12] used, [11:0] ignored
- mmu_we  in  1  load mmu_base_i, flush TLB, abort walk
- mmu_base_o  out  32  current base register
- v_addr_i  in  32  virtual address
- v_data_i  in  32  write data
- v_data_o  out  32  read data (= data_i)
- v_we_i  in  1  virtual write request
- v_rd_i  in  1  virtual read request
- v_ack_o  out  1  access complete
- addr_o  out  32  physical bus address
- data_i  in  32  bus read data
- data_o  out  32  bus write data
- we_o  out  1  bus write
- rd_o  out  1  bus read
- ack_i  in  1  bus acknowledge
- page_fault  out  1  one-cycle fault pulse
- page_fault_addr  out  32  faulting virtual address, held until next fault

Behaviour:
- PTE/PDE format:
  - [31:12] frame number.
  - bit0 V (valid).
  - bit1 W (writable; meaningful in PTE only).
- Walk addresses:
  - PDE at {base[31:12], v_addr[31:22], 2'b00}.
  - PTE at {PDE[31:12], v_addr[21:12], 2'b00}.
- TLB entry: valid, vpn[19:0], ppn[19:0], w.
  - Hit = valid && vpn == v_addr_i[31:12].
  - At most one hit is guaranteed by construction: fill only occurs on miss.
- Reset (async):
  - All entries invalid; base = 0; state IDLE; replacement pointer 0.
  - page_fault = 0; page_fault_addr = 0.
  - All bus outputs 0; v_ack_o = 0.
- FSM states: IDLE, PDE_RD, PTE_RD, FAULT.
- IDLE with request (v_rd_i | v_we_i):
  - Hit, and read or W=1: combinational pass-through.
    - addr_o = {ppn, v_addr_i[11:0]}; we_o/rd_o/data_o follow the request.
    - v_ack_o = ack_i. Zero added latency.
  - Hit, write with W=0: no bus access; go to FAULT.
  - Miss: go to PDE_RD.
- PDE_RD:
  - rd_o = 1, addr_o = PDE address, held until ack_i.
  - On ack_i: latch PDE; V=0 -> FAULT; else -> PTE_RD.
- PTE_RD:
  - Same handshake on the PTE address.
  - On ack_i with V=0: go to FAULT.
  - On ack_i with V=1: fill victim entry, go to IDLE. The access then hits next cycle, so a miss costs 2 bus reads + 1 cycle.
- FAULT:
  - page_fault = 1 for exactly one cycle; page_fault_addr <= v_addr_i.
  - Return to IDLE. No TLB fill occurs on a fault.
  - If the requester keeps the request asserted, the walk repeats.
- v_ack_o is 0 in every state except an IDLE hit.
- Victim selection:
  - Lowest-index invalid entry if any.
  - Else the round-robin pointer, which increments mod TLB_ENTRIES on each fill that uses it.
- mmu_we (any state):
  - Next edge: base <= mmu_base_i; all entries invalid; pointer 0; state IDLE.
  - A walk in progress is abandoned: rd_o drops next cycle and a late ack_i is ignored.
  - mmu_we has priority over a fill in the same cycle.
- Request dropped mid-walk: the walk completes and fills; no ack is given.
- Reset mid-walk: immediate return to reset values.

Decomposition:
- Shared package mmu_pkg:
  - PTE_V = 0, PTE_W = 1.
  - Field ranges: VPN [31:12], DIR [31:22], TBL [21:12].
  - FSM state enum.
  - tlb_entry_t struct.
- One sub-module, mmu_tlb_array:
  - Entry storage and parallel compare.
  - hit / hit_idx / hit_ppn / hit_w outputs.
  - Victim selection and flush.
- FSM and bus muxing stay in mmu_tlbn.

Test Plan:
- Reset, base=0x0001_0000, PDE[0x01]@0x0001_0004=0x0002_0001, PTE[0x23]@0x0002_008C=0x0005_5003, read 0x0042_3ABC
  -> bus reads 0x0001_0004 then 0x0002_008C; then rd_o at 0x0005_5ABC; v_ack_o follows ack_i.
- Repeat read 0x0042_3FF0 -> no walk; addr_o = 0x0005_5FF0 in the same cycle.
- Write to a page whose PTE = 0x0006_6001 (W=0)
  -> walk, fill, then page_fault pulse 1 cycle, page_fault_addr = v_addr; we_o never asserted.
- Misses on 5 distinct pages with TLB_ENTRIES=4
  -> fills go to entries 0,1,2,3, then entry 0 (pointer); the first page misses again.
- PDE V=0 -> page_fault pulse, no fill; a second identical request walks again.
- mmu_we asserted while in PTE_RD
  -> rd_o low next cycle; base updated; all entries miss; a late ack_i is ignored.
